// File: rtl/frame_buffer_tri.sv
// frame_buffer_tri: triple-buffered pixel frame store.
// Writer streams pixels in raster order into bank W; the reader displays bank D;
// the third bank F holds a pending complete frame (pend) or is free.
// Completed frames are handed to the reader only on rd_sof, so reads never tear.

// One frame bank: single sync write port, single sync read port, no reset on
// the array or read register so it maps onto block RAM.
module fb_bank #(
  parameter int DEPTH = 4800,
  parameter int AW    = 13,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [IW-1:0] wi, ri;

  // Out-of-range read addresses are masked at the top level; clamp here so the
  // array is never indexed past its end.
  assign wi = IW'(waddr);
  assign ri = (int'(raddr) < DEPTH) ? IW'(raddr) : '0;

  // Memory write and registered read.
  always_ff @(posedge clk) begin
    if (we) mem[wi] <= wdata;
    rdata <= mem[ri];
  end
endmodule

module frame_buffer_tri #(
  parameter int C_IMG_COLS    = 80,
  parameter int C_IMG_ROWS    = 60,
  parameter int C_IMG_PXLS    = C_IMG_COLS*C_IMG_ROWS,
  parameter int C_NB_IMG_PXLS = 13,
  parameter int C_NB_BUF      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_sof,
  input  logic                     wr_valid,
  input  logic [C_NB_BUF-1:0]      wr_data,
  input  logic                     rd_sof,
  input  logic [C_NB_IMG_PXLS-1:0] rd_addr,
  output logic [C_NB_BUF-1:0]      rd_data,
  output logic [1:0]               rd_bank,
  output logic [1:0]               wr_bank,
  output logic                     has_frame,
  output logic                     frame_done,
  output logic                     frame_short,
  output logic                     frame_ovw
);
  localparam logic [C_NB_IMG_PXLS-1:0] LAST = C_NB_IMG_PXLS'(C_IMG_PXLS-1);

  typedef enum logic {W_IDLE, W_FILL} wstate_e;

  wstate_e                  st, st_n;
  logic [C_NB_IMG_PXLS-1:0] wr_cnt, wr_cnt_n, waddr;
  logic [1:0]               d_bank, w_bank, f_bank, d_n, w_n;
  logic                     pend, pend_n, has_n;
  logic                     we, done, short_n, ovw_n;
  logic [1:0]               rsel;
  logic                     rvld;
  logic [2:0][C_NB_BUF-1:0] bank_q;

  // Roles always form a permutation of {0,1,2}, so F is what is left over.
  assign f_bank = 2'd3 - d_bank - w_bank;

  // Write FSM next state, address generation and role handoff.
  always_comb begin
    st_n     = st;
    wr_cnt_n = wr_cnt;
    d_n      = d_bank;
    w_n      = w_bank;
    pend_n   = pend;
    has_n    = has_frame;
    short_n  = 1'b0;
    ovw_n    = 1'b0;
    we       = 1'b0;
    waddr    = wr_cnt;
    if (wr_valid && wr_sof) begin
      // A sof always restarts at pixel 0 of the same bank.
      we       = 1'b1;
      waddr    = '0;
      wr_cnt_n = C_NB_IMG_PXLS'(1);
      st_n     = W_FILL;
      short_n  = (st == W_FILL);
    end else if (wr_valid && st == W_FILL) begin
      we       = 1'b1;
      wr_cnt_n = wr_cnt + 1'b1;
    end
    done = we && (waddr == LAST);
    if (done) begin
      st_n     = W_IDLE;
      wr_cnt_n = '0;
      ovw_n    = pend;
    end
    if (done && rd_sof) begin
      // Reader grabs the frame just finished; any older pending frame is dropped
      // and its bank becomes the new write target.
      d_n    = w_bank;
      w_n    = f_bank;
      pend_n = 1'b0;
      has_n  = 1'b1;
    end else if (done) begin
      w_n    = f_bank;
      pend_n = 1'b1;
    end else if (rd_sof && pend) begin
      d_n    = f_bank;
      pend_n = 1'b0;
      has_n  = 1'b1;
    end
  end

  // State, role and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= W_IDLE;
      wr_cnt      <= '0;
      d_bank      <= 2'd0;
      w_bank      <= 2'd1;
      pend        <= 1'b0;
      has_frame   <= 1'b0;
      frame_done  <= 1'b0;
      frame_short <= 1'b0;
      frame_ovw   <= 1'b0;
      rsel        <= 2'd0;
      rvld        <= 1'b0;
    end else begin
      st          <= st_n;
      wr_cnt      <= wr_cnt_n;
      d_bank      <= d_n;
      w_bank      <= w_n;
      pend        <= pend_n;
      has_frame   <= has_n;
      frame_done  <= done;
      frame_short <= short_n;
      frame_ovw   <= ovw_n;
      // Read from the post-swap display bank so a rd_sof cycle already sees
      // the new frame.
      rsel        <= d_n;
      rvld        <= (int'(rd_addr) < C_IMG_PXLS);
    end
  end

  for (genvar b = 0; b < 3; b++) begin : g_bank
    fb_bank #(.DEPTH(C_IMG_PXLS), .AW(C_NB_IMG_PXLS), .DW(C_NB_BUF)) u_bank (
      .clk  (clk),
      .we   (we && (w_bank == 2'(b))),
      .waddr(waddr),
      .wdata(wr_data),
      .raddr(rd_addr),
      .rdata(bank_q[b])
    );
  end

  assign rd_data = rvld ? bank_q[rsel] : '0;
  assign rd_bank = d_bank;
  assign wr_bank = w_bank;
endmodule

// File: tb/tb_frame_buffer_tri.sv
// Bench for frame_buffer_tri on a 4x2 image: reads push expected data into a
// scoreboard queue, a monitor pops and compares when the read result appears.
module tb_frame_buffer_tri;
  localparam int COLS = 4, ROWS = 2, PXLS = 8, AW = 4, DW = 16;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          wr_sof = 1'b0, wr_valid = 1'b0, rd_sof = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic [1:0]    rd_bank, wr_bank;
  logic          has_frame, frame_done, frame_short, frame_ovw;

  int total = 0, bad = 0;
  int n_done = 0, n_short = 0, n_ovw = 0;
  logic [DW-1:0] expq[$];
  logic rd_chk = 1'b0, chk_d = 1'b0;

  frame_buffer_tri #(.C_IMG_COLS(COLS), .C_IMG_ROWS(ROWS), .C_IMG_PXLS(PXLS),
                     .C_NB_IMG_PXLS(AW), .C_NB_BUF(DW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_sof(wr_sof), .wr_valid(wr_valid),
    .wr_data(wr_data), .rd_sof(rd_sof), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_bank(rd_bank), .wr_bank(wr_bank), .has_frame(has_frame),
    .frame_done(frame_done), .frame_short(frame_short), .frame_ovw(frame_ovw));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: read result one cycle after a tracked read; pulse counting; roles distinct.
  always @(posedge clk) chk_d <= rd_chk;
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done)  n_done++;
      if (frame_short) n_short++;
      if (frame_ovw)   n_ovw++;
      chk("roles_distinct", int'(rd_bank != wr_bank && rd_bank != 2'd3 && wr_bank != 2'd3), 1);
      if (chk_d) begin
        if (expq.size() == 0) chk("scoreboard_underflow", 1, 0);
        else chk("rd_data", int'(rd_data), int'(expq.pop_front()));
      end
    end
  end

  // One clock of stimulus: optional pixel and optional tracked read.
  task automatic step(input logic wv, input logic ws, input logic [DW-1:0] wd,
                      input logic rs, input logic [AW-1:0] ra,
                      input logic rc, input logic [DW-1:0] re);
    wr_valid = wv; wr_sof = ws; wr_data = wd;
    rd_sof = rs; rd_addr = ra; rd_chk = rc;
    if (rc) expq.push_back(re);
    @(posedge clk); #1;
    wr_valid = 1'b0; wr_sof = 1'b0; rd_sof = 1'b0; rd_chk = 1'b0;
  endtask

  task automatic frame(input logic [DW-1:0] base);
    for (int i = 0; i < PXLS; i++) step(1'b1, i == 0, base + DW'(i), 1'b0, '0, 1'b0, '0);
  endtask

  task automatic rd(input logic s, input logic [AW-1:0] a, input logic [DW-1:0] e);
    step(1'b0, 1'b0, '0, s, a, 1'b1, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset rd_bank", rd_bank, 0);
    chk("reset wr_bank", wr_bank, 1);
    chk("reset has_frame", has_frame, 0);
    chk("reset rd_data", rd_data, 0);
    @(posedge clk); #1;

    // Basic frame into bank 1, then swap.
    frame(16'h10);
    @(negedge clk);
    chk("t1 frame_done", frame_done, 1);
    chk("t1 wr_bank", wr_bank, 2);
    chk("t1 rd_bank before swap", rd_bank, 0);
    chk("t1 has_frame before swap", has_frame, 0);
    @(posedge clk); #1;
    rd(1'b1, 0, 16'h10);
    rd(1'b0, 7, 16'h17);
    @(negedge clk);
    chk("t1 rd_bank", rd_bank, 1);
    chk("t1 has_frame", has_frame, 1);
    @(posedge clk); #1;

    // Short frame then restart into same bank (2).
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, 16'hA0 + DW'(i), 1'b0, '0, 1'b0, '0);
    frame(16'h20);
    idle(1);
    chk("t2 short count", n_short, 1);
    chk("t2 done count", n_done, 2);
    chk("t2 wr_bank", wr_bank, 0);
    rd(1'b1, 0, 16'h20);
    for (int i = 1; i < PXLS; i++) rd(1'b0, AW'(i), 16'h20 + DW'(i));
    idle(1);
    chk("t2 rd_bank", rd_bank, 2);

    // Overwrite: A into bank 0, B into bank 1 with no read swap.
    frame(16'h30);
    frame(16'h40);
    idle(1);
    chk("t3 ovw count", n_ovw, 1);
    chk("t3 wr_bank", wr_bank, 0);
    rd(1'b1, 0, 16'h40);
    rd(1'b0, 7, 16'h47);
    rd(1'b0, 8, 16'h0);
    idle(1);
    chk("t3 rd_bank", rd_bank, 1);

    // Simultaneous: A pending in bank 0, B (bank 2) completes with rd_sof.
    frame(16'h50);
    for (int i = 0; i < PXLS-1; i++) step(1'b1, i == 0, 16'h60 + DW'(i), 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, 16'h67, 1'b1, 0, 1'b1, 16'h60);
    for (int i = 1; i < PXLS; i++) rd(1'b0, AW'(i), 16'h60 + DW'(i));
    idle(1);
    chk("t4 ovw count", n_ovw, 2);
    chk("t4 done count", n_done, 6);
    chk("t4 rd_bank", rd_bank, 2);
    chk("t4 wr_bank", wr_bank, 0);

    // Async reset mid-fill with rd_sof held.
    for (int i = 0; i < 3; i++) step(1'b1, i == 0, 16'h70 + DW'(i), 1'b0, '0, 1'b0, '0);
    wr_valid = 1'b1; wr_data = 16'h73; rd_sof = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst rd_bank", rd_bank, 0);
    chk("rst wr_bank", wr_bank, 1);
    chk("rst has_frame", has_frame, 0);
    chk("rst rd_data", rd_data, 0);
    chk("rst pulses", int'({frame_done, frame_short, frame_ovw}), 0);
    wr_valid = 1'b0; rd_sof = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    frame(16'h80);
    @(negedge clk);
    chk("post-rst frame_done", frame_done, 1);
    chk("post-rst wr_bank", wr_bank, 2);
    @(posedge clk); #1;
    rd(1'b1, 0, 16'h80);
    rd(1'b0, 7, 16'h87);
    idle(1);
    chk("post-rst rd_bank", rd_bank, 1);
    chk("post-rst short count", n_short, 1);
    idle(1);
    chk("scoreboard drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
